// File: rtl/cntr_mod.sv
// Parametrised modulo-N up/down counter with load, wrap/saturate mode,
// terminal count, cascade carry and a sticky overflow flag.
module cntr_mod #(
  parameter int MODULUS     = 12,
  parameter int WIDTH       = $clog2(MODULUS),
  parameter int RESET_VALUE = 0,
  parameter bit SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             ovf,
  output logic             load_err
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] Q_RST   = WIDTH'(RESET_VALUE);

  logic [WIDTH:0] q_inc;
  logic [WIDTH:0] q_dec;
  logic           at_top;
  logic           at_bottom;
  logic           load_ok;
  logic           end_hit;

  // One extra bit keeps MODULUS = 2^WIDTH exact; the borrow bit flags q == 0.
  assign q_inc     = {1'b0, q} + 1'b1;
  assign q_dec     = {1'b0, q} - 1'b1;
  assign at_top    = (q_inc == MOD_EXT);
  assign at_bottom = q_dec[WIDTH];
  assign load_ok   = ({1'b0, d} < MOD_EXT);

  assign tc      = up ? at_top : at_bottom;
  assign end_hit = en && tc && !load;
  assign co      = end_hit && !SATURATE;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q        <= Q_RST;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) q <= d;
        else         load_err <= 1'b1;
      end else if (en) begin
        if (end_hit) begin
          if (!SATURATE) q <= up ? '0 : Q_MAX;
        end else begin
          q <= up ? q_inc[WIDTH-1:0] : q_dec[WIDTH-1:0];
        end
      end
      // A wrap or a blocked count outranks a simultaneous clear.
      if (end_hit)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cntr_mod.sv
// Scoreboard bench for cntr_mod: four single instances (wrap, saturate,
// reset value 3, modulus 16) on shared stimulus, plus a mod-10/mod-6 cascade.
module tb_cntr_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       en      = 1'b0;
  logic       up      = 1'b1;
  logic       load    = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] d       = '0;

  logic [3:0][3:0] q_v;
  logic [3:0]      tc_v, co_v, ovf_v, lerr_v;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cntr_mod #(
      .MODULUS    (g == 3 ? 16 : 12),
      .RESET_VALUE(g == 2 ? 3 : 0),
      .SATURATE   (g == 1)
    ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .up      (up),
      .load    (load),
      .d       (d),
      .clr_ovf (clr_ovf),
      .q       (q_v[g]),
      .tc      (tc_v[g]),
      .co      (co_v[g]),
      .ovf     (ovf_v[g]),
      .load_err(lerr_v[g])
    );
  end

  logic       c_en = 1'b0;
  logic [3:0] u_q;
  logic [2:0] t_q;
  logic       u_tc, u_co, u_ovf, u_le, t_tc, t_co, t_ovf, t_le;

  cntr_mod #(.MODULUS(10)) u_units (
    .clk(clk), .reset_n(reset_n), .en(c_en), .up(1'b1), .load(1'b0), .d(4'd0),
    .clr_ovf(1'b0), .q(u_q), .tc(u_tc), .co(u_co), .ovf(u_ovf), .load_err(u_le)
  );

  cntr_mod #(.MODULUS(6)) u_tens (
    .clk(clk), .reset_n(reset_n), .en(u_co), .up(1'b1), .load(1'b0), .d(3'd0),
    .clr_ovf(1'b0), .q(t_q), .tc(t_tc), .co(t_co), .ovf(t_ovf), .load_err(t_le)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int inst;
    int q;
    int ovf;
    int lerr;
  } exp_t;

  exp_t sb[$];

  int mods[4] = '{12, 12, 12, 16};
  bit sats[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int rvs[4]  = '{0, 0, 3, 0};
  int mq[4]   = '{0, 0, 0, 0};
  int mo[4]   = '{0, 0, 0, 0};
  int cnt     = 0;
  bit armed   = 1'b0;

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      if (x.inst == 4) begin
        chk("pair", int'(u_q) + 10 * int'(t_q), x.q);
      end else begin
        chk($sformatf("q[%0d]", x.inst), int'(q_v[x.inst]), x.q);
        chk($sformatf("ovf[%0d]", x.inst), int'(ovf_v[x.inst]), x.ovf);
        chk($sformatf("load_err[%0d]", x.inst), int'(lerr_v[x.inst]), x.lerr);
      end
    end
  endtask

  task automatic step(input bit rn, input bit e, input bit u, input bit l,
                      input int dv, input bit c);
    exp_t x;
    int   nq;
    bit   set, le, tcx;
    reset_n = rn; en = e; up = u; load = l; d = 4'(dv); clr_ovf = c;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (armed) begin
        tcx = u ? (mq[i] == mods[i] - 1) : (mq[i] == 0);
        chk($sformatf("tc[%0d]", i), int'(tc_v[i]), int'(tcx));
        chk($sformatf("co[%0d]", i), int'(co_v[i]), int'(e && tcx && !l && !sats[i]));
      end
      nq = mq[i]; set = 1'b0; le = 1'b0;
      if (!rn) begin
        nq = rvs[i];
        mo[i] = 0;
      end else begin
        if (l) begin
          if (dv < mods[i]) nq = dv;
          else le = 1'b1;
        end else if (e) begin
          if (u) begin
            if (mq[i] == mods[i] - 1) begin set = 1'b1; if (!sats[i]) nq = 0; end
            else nq = mq[i] + 1;
          end else begin
            if (mq[i] == 0) begin set = 1'b1; if (!sats[i]) nq = mods[i] - 1; end
            else nq = mq[i] - 1;
          end
        end
        if (set) mo[i] = 1;
        else if (c) mo[i] = 0;
      end
      mq[i] = nq;
      x.inst = i; x.q = nq; x.ovf = mo[i]; x.lerr = int'(le);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    armed = 1'b1;
    drain();
  endtask

  task automatic cstep(input bit e);
    exp_t x;
    c_en = e;
    #1;
    chk("units_tc", int'(u_tc), int'(cnt % 10 == 9));
    chk("tens_co", int'(t_co), int'(e && cnt == 59));
    if (e) cnt = (cnt + 1) % 60;
    x.inst = 4; x.q = cnt; x.ovf = 0; x.lerr = 0;
    sb.push_back(x);
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (12) step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    step(1, 0, 1, 1, 7, 0);
    step(1, 0, 1, 1, 13, 0);
    step(1, 1, 1, 1, 15, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 2, 0);
    step(1, 0, 0, 1, 0, 1);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 5, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    repeat (80) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
    end

    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    cnt = 0;
    repeat (60) cstep(1'b1);
    cstep(1'b0);
    chk("units_ovf", int'(u_ovf), 1);
    chk("tens_ovf", int'(t_ovf), 1);
    chk("units_load_err", int'(u_le), 0);
    chk("tens_load_err", int'(t_le), 0);
    chk("tens_tc", int'(t_tc), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cntr_mod.md
# cntr_mod

Parametrised modulo-N up/down counter. It generalises the fixed mod-12 counter `cntr12`, adding:
- a configurable modulus;
- count enable, direction control and synchronous parallel load;
- wrap or saturate mode;
- a terminal-count output and a cascade carry, so instances chain into multi-digit counters.

Used as a timebase, digit counter or event counter in the team's small sequential designs.

## Interface

Parameters:
- `MODULUS`, 12, count range is 0 to MODULUS-1; legal range 2 to 2^16.
- `WIDTH`, `$clog2(MODULUS)`, width of `q`/`d`; must satisfy 2^WIDTH >= MODULUS.
- `RESET_VALUE`, 0, value of `q` after reset; must be < MODULUS.
- `SATURATE`, 0, 0 = wrap at the ends, 1 = hold at the ends.

Ports:
- `clk`, input, 1, the single clock; all state changes on its rising edge.
- `reset_n`, input, 1, reset, synchronous, active-low.
- `en`, input, 1, count enable.
- `up`, input, 1, direction: 1 = increment, 0 = decrement.
- `load`, input, 1, synchronous parallel load request.
- `d`, input, WIDTH, load value.
- `clr_ovf`, input, 1, clears the sticky `ovf` flag.
- `q`, output, WIDTH, registered count.
- `tc`, output, 1, terminal count (combinational from `q` and `up`).
- `co`, output, 1, cascade carry/borrow (combinational).
- `ovf`, output, 1, sticky overflow/underflow flag (registered).
- `load_err`, output, 1, one-cycle pulse for a rejected load (registered).

## Operation

Per-edge priority, highest first:
- **Reset:** `reset_n`=0 → `q`=RESET_VALUE, `ovf`=0, `load_err`=0. All other inputs are ignored.
- **Load, legal:** `load`=1 and `d` < MODULUS → `q`=`d`, independent of `en`.
- **Load, illegal:** `load`=1 and `d` >= MODULUS → `q` holds and `load_err`=1 for one cycle.
- **Count:** `load`=0, `en`=1:
  - up and `q`=MODULUS-1 → `q`=0 (wrap) or hold (SATURATE);
  - down and `q`=0 → `q`=MODULUS-1 (wrap) or hold (SATURATE);
  - otherwise `q`=`q`±1.
- **Idle:** `en`=0, `load`=0 → `q` holds.

Outputs:
- `tc` = up ? (`q`==MODULUS-1) : (`q`==0).
- `co` = `en` & `tc` & ~`load` & (SATURATE==0). `co` is therefore always 0 in saturate mode. Chain stages by driving stage k+1 `en` from stage k `co` with a shared `up`.
- `ovf`:
  - set on any edge where the counter wraps (wrap mode) or where a count is blocked at an end (saturate mode);
  - cleared by `clr_ovf`;
  - if set and clear occur on the same edge, set wins.
- `load_err` is 0 on every edge without an illegal load.

Width and arithmetic rules:
- Arithmetic is performed in WIDTH+1 bits, so MODULUS = 2^WIDTH is handled without reliance on natural overflow.
- `q` never leaves 0..MODULUS-1 by any input sequence.

## Timing

- `q`, `ovf` and `load_err` are registered, with one clock of latency from the inputs.
- `tc` and `co` are combinational from `q`, `up`, `en` and `load`, with zero latency. `co` is valid in the same cycle in which the wrap edge occurs.
- Reset asserted mid-count takes effect on the next rising edge. No count or load occurs on that edge.
- The first count happens on the first edge with `reset_n`=1 and `en`=1.
- After reset with RESET_VALUE=0 and `up`=0, `tc`=1 immediately.

## Test plan

- **Reset and wrap up:** reset_n=0 for 2 cycles, then en=1, up=1.
  - Response: `q` = 0,1,…,11,0.
  - `tc`/`co`=1 only while `q`=11; `ovf` sets on the 11→0 edge.
- **Down wrap:** from `q`=0 with en=1, up=0.
  - Response: `q`=11, `ovf`=1; `clr_ovf` pulse → `ovf`=0.
  - Set and clear on the same edge → `ovf` stays 1.
- **Load:**
  - `load`=1, `d`=7, en=0 → `q`=7 next cycle.
  - `d`=13 → `q` unchanged, `load_err`=1 for exactly one cycle.
  - `load` and `en` both high → load wins.
- **Saturate:** SATURATE=1, MODULUS=12.
  - Count up past 11 → `q` holds at 11, `co`=0, `ovf`=1.
  - Count down past 0 → `q` holds at 0.
- **Reset mid-operation:** reset_n=0 while `q`=5, en=1 → `q`=RESET_VALUE on the next edge. A run with RESET_VALUE=3 returns `q`=3.
- **Cascade:** two instances, MODULUS=10 (units) and MODULUS=6 (tens); units `co` drives tens `en`.
  - 60 enables → pair reads 59 and then 00.
  - Tens `co` is high exactly on the 59→00 edge.
